// File: rtl/floor_request_scheduler.sv
// Floor request scheduler: latches cab/hall calls into a pending map
// and feeds the elevator FSM one SCAN-ordered target at a time.
module floor_request_scheduler #(
   parameter int FLOORS  = 8,
   parameter int FLOOR_W = 3,
   parameter int TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLOORS-1:0]  cab_call,
   input  logic [FLOORS-1:0]  hall_call,
   input  logic [FLOOR_W-1:0] current_floor,
   input  logic               fsm_idle,
   input  logic               door,
   input  logic               emergency_stop,
   output logic [FLOOR_W-1:0] req_floor,
   output logic               req_valid,
   output logic [FLOORS-1:0]  pending,
   output logic               dir_up,
   output logic               busy,
   output logic               timeout_err
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [2:0] {
      IDLE, SELECT, ISSUE, WAIT, DWELL, HOLD
   } state_t;

   state_t             state, state_n;
   logic [FLOOR_W-1:0] target, sel_tgt, lo_up, hi_dn;
   logic [CNT_W-1:0]   cnt;
   logic [FLOORS-1:0]  calls, ret_mask;
   logic               here, any_up, any_dn, sel_dir;
   logic               retire, expired;

   assign retire  = (state == WAIT) && door && !emergency_stop
                    && (current_floor == target);
   assign expired = (state == WAIT) && (cnt == CNT_W'(TIMEOUT - 1));

   // A press at the floor whose door is open is already being served.
   always_comb begin
      calls    = '0;
      ret_mask = '0;
      for (int i = 0; i < FLOORS; i++) begin
         calls[i]    = (cab_call[i] | hall_call[i])
                       && !(door && FLOOR_W'(i) == current_floor);
         ret_mask[i] = retire && (FLOOR_W'(i) == target);
      end
   end

   always_comb begin
      here   = 1'b0;
      any_up = 1'b0;
      any_dn = 1'b0;
      lo_up  = '0;
      hi_dn  = '0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && FLOOR_W'(i) > current_floor) begin
            any_up = 1'b1;
            lo_up  = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < FLOORS; i++) begin
         if (pending[i] && FLOOR_W'(i) < current_floor) begin
            any_dn = 1'b1;
            hi_dn  = FLOOR_W'(i);
         end
         if (pending[i] && FLOOR_W'(i) == current_floor)
            here = 1'b1;
      end
   end

   always_comb begin
      sel_tgt = current_floor;
      sel_dir = dir_up;
      if (here) begin
         sel_tgt = current_floor;
      end else if (dir_up) begin
         sel_tgt = any_up ? lo_up : hi_dn;
         sel_dir = any_up;
      end else begin
         sel_tgt = any_dn ? hi_dn : lo_up;
         sel_dir = !any_dn;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      if (emergency_stop) begin
         state_n = HOLD;
      end else begin
         unique case (state)
            IDLE:
               if (|pending && fsm_idle && !door) state_n = SELECT;
            SELECT: state_n = ISSUE;
            ISSUE:  state_n = WAIT;
            WAIT:
               if (retire)       state_n = DWELL;
               else if (expired) state_n = IDLE;
            DWELL:
               if (!door && fsm_idle) state_n = IDLE;
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      req_valid   = (state == ISSUE) && !emergency_stop;
      busy        = (state != IDLE);
      timeout_err = expired && !retire && !emergency_stop;
   end

   assign req_floor = target;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
         target  <= '0;
         dir_up  <= 1'b1;
         cnt     <= '0;
      end else begin
         pending <= (pending & ~ret_mask) | calls;
         if (state == SELECT && !emergency_stop) begin
            target <= sel_tgt;
            dir_up <= sel_dir;
         end
         if (state == ISSUE)     cnt <= '0;
         else if (state == WAIT) cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Bench for floor_request_scheduler: directed trips with a scoreboard
// of expected strobe floors checked by an independent monitor.
module tb_floor_request_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] cab_call, hall_call, pending;
   logic [2:0] current_floor, req_floor;
   logic       fsm_idle, door, emergency_stop;
   logic       req_valid, dir_up, busy, timeout_err;

   int         total = 0;
   int         bad = 0;
   logic [2:0] exp_q[$];
   logic [2:0] e;
   logic       prev_valid = 1'b0;
   logic       early;

   floor_request_scheduler #(
      .FLOORS(8), .FLOOR_W(3), .TIMEOUT(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .cab_call(cab_call),
      .hall_call(hall_call),
      .current_floor(current_floor),
      .fsm_idle(fsm_idle),
      .door(door),
      .emergency_stop(emergency_stop),
      .req_floor(req_floor),
      .req_valid(req_valid),
      .pending(pending),
      .dir_up(dir_up),
      .busy(busy),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_strobe(input string name);
      int n = 0;
      while (req_valid !== 1'b1 && n < 20) begin
         step(1);
         n++;
      end
      chk(name, {31'b0, req_valid}, 32'd1);
   endtask

   // Monitor: every strobe must match the oldest expected floor.
   always @(negedge clk) begin
      if (req_valid === 1'b1) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got floor %0d expected none",
                     req_floor);
         end else begin
            e = exp_q.pop_front();
            if (req_floor !== e || prev_valid) begin
               bad++;
               $display("FAIL sb_floor: got %0d (b2b=%0b) expected %0d",
                        req_floor, prev_valid, e);
            end
         end
      end
      prev_valid = req_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      cab_call = '0;
      hall_call = '0;
      current_floor = 3'd0;
      fsm_idle = 1'b1;
      door = 1'b0;
      emergency_stop = 1'b0;
      step(2);
      chk("rst_pending", pending, 0);
      chk("rst_dir_up", dir_up, 1);
      chk("rst_req_valid", req_valid, 0);
      chk("rst_req_floor", req_floor, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout_err, 0);
      reset = 1'b1;
      step(1);

      // single call, 3-cycle latency
      cab_call = 8'h08;
      step(1);
      chk("t1_pending", pending, 8'h08);
      cab_call = '0;
      exp_q.push_back(3'd3);
      step(1);
      chk("t1_busy_select", busy, 1);
      chk("t1_no_early_strobe", req_valid, 0);
      step(1);
      chk("t1_strobe", req_valid, 1);
      chk("t1_req_floor", req_floor, 3);
      step(1);
      door = 1'b1;
      current_floor = 3'd3;
      step(1);
      chk("t1_retired", pending, 0);
      chk("t1_busy_dwell", busy, 1);
      door = 1'b0;
      step(1);
      chk("t1_idle", busy, 0);

      // SCAN ordering from floor 2 going up
      current_floor = 3'd2;
      cab_call = 8'hA1;
      step(1);
      cab_call = '0;
      exp_q.push_back(3'd5);
      exp_q.push_back(3'd7);
      exp_q.push_back(3'd0);
      for (int k = 0; k < 3; k++) begin
         logic [2:0] f;
         f = (k == 0) ? 3'd5 : (k == 1) ? 3'd7 : 3'd0;
         if (k == 2) chk("t2_dir_before", dir_up, 1);
         wait_strobe("t2_strobe");
         step(1);
         current_floor = f;
         door = 1'b1;
         step(1);
         door = 1'b0;
         step(1);
      end
      chk("t2_dir_after", dir_up, 0);
      chk("t2_pending", pending, 0);

      // call at the current floor, repeat press while door open
      current_floor = 3'd4;
      hall_call = 8'h10;
      step(1);
      hall_call = '0;
      exp_q.push_back(3'd4);
      wait_strobe("t3_strobe");
      step(1);
      door = 1'b1;
      hall_call = 8'h10;
      step(1);
      hall_call = '0;
      chk("t3_repeat_ignored", pending, 0);
      chk("t3_dir_kept", dir_up, 0);
      door = 1'b0;
      step(1);

      // emergency stop during WAIT to floor 6
      cab_call = 8'h40;
      step(1);
      cab_call = '0;
      exp_q.push_back(3'd6);
      wait_strobe("t4_strobe");
      step(2);
      emergency_stop = 1'b1;
      step(1);
      chk("t4_hold_valid", req_valid, 0);
      chk("t4_hold_pending", pending, 8'h40);
      chk("t4_hold_busy", busy, 1);
      step(3);
      chk("t4_hold_still", req_valid, 0);
      emergency_stop = 1'b0;
      exp_q.push_back(3'd6);
      step(3);
      chk("t4_reissue", req_valid, 1);
      chk("t4_reissue_floor", req_floor, 6);
      step(1);
      current_floor = 3'd6;
      door = 1'b1;
      step(1);
      door = 1'b0;
      step(1);
      chk("t4_pending", pending, 0);

      // WAIT timeout to floor 5
      cab_call = 8'h20;
      step(1);
      cab_call = '0;
      exp_q.push_back(3'd5);
      wait_strobe("t5_strobe");
      early = 1'b0;
      for (int k = 1; k <= 63; k++) begin
         step(1);
         if (timeout_err) early = 1'b1;
      end
      chk("t5_no_early_timeout", early, 0);
      step(1);
      chk("t5_timeout_pulse", timeout_err, 1);
      chk("t5_still_pending", pending, 8'h20);
      exp_q.push_back(3'd5);
      step(1);
      chk("t5_pulse_one_cycle", timeout_err, 0);
      wait_strobe("t5_reissue");
      step(1);
      current_floor = 3'd5;
      door = 1'b1;
      step(1);
      door = 1'b0;
      step(1);

      // asynchronous reset mid-WAIT
      cab_call = 8'h04;
      step(1);
      cab_call = '0;
      exp_q.push_back(3'd2);
      wait_strobe("t6_strobe");
      step(1);
      cab_call = 8'h80;
      step(1);
      cab_call = '0;
      #2;
      reset = 1'b0;
      #1;
      chk("t6_async_busy", busy, 0);
      chk("t6_async_pending", pending, 0);
      chk("t6_async_dir", dir_up, 1);
      chk("t6_async_valid", req_valid, 0);
      chk("t6_async_floor", req_floor, 0);
      step(1);
      reset = 1'b1;
      step(4);
      chk("t6_after_pending", pending, 0);
      chk("t6_after_busy", busy, 0);
      chk("sb_drain", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
